// File: rtl/id_operand_stage_pkg.sv
// Shared constants and stage-control helpers for the ID operand stage:
// stall-bus layout, register-address width and the stage-register action decode.
package id_operand_stage_pkg;

  localparam int STALL_W_DEF    = 6;
  localparam int STALL_IDX_ID   = 1;  // this stage
  localparam int STALL_IDX_NEXT = 2;  // downstream (EX) stage
  localparam int REG_ADDR_W     = 5;
  localparam int INST_W         = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    STG_HOLD,
    STG_ADVANCE,
    STG_BUBBLE,
    STG_FLUSH
  } stage_op_e;

  // Flush beats bubble beats advance; a stall of both stages freezes.
  function automatic stage_op_e decode_stage_op(input logic flush,
                                                input logic stall_id,
                                                input logic stall_next);
    if (flush)                       return STG_FLUSH;
    else if (stall_id && !stall_next) return STG_BUBBLE;
    else if (!stall_id)              return STG_ADVANCE;
    else                             return STG_HOLD;
  endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// Forwarding bus from the later pipeline stages (channel 0 = EX, last = writeback)
// into the ID operand stage.
interface id_operand_stage_if
  import id_operand_stage_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32
);

  logic [NUM_FWD-1:0]            fwd_we;
  logic [REG_ADDR_W*NUM_FWD-1:0] fwd_waddr;
  logic [DATA_W*NUM_FWD-1:0]     fwd_wdata;
  logic [NUM_FWD-1:0]            fwd_is_load;

  modport master (
    output fwd_we,
    output fwd_waddr,
    output fwd_wdata,
    output fwd_is_load
  );

  modport slave (
    input fwd_we,
    input fwd_waddr,
    input fwd_wdata,
    input fwd_is_load
  );

endinterface

// File: rtl/id_operand_stage_fwd_mux.sv
// One source operand's bypass selector: youngest matching channel wins, register 0
// is hard-wired to zero, and the load flag of the winning channel is reported.
module fwd_mux
  import id_operand_stage_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32
) (
  input  logic [REG_ADDR_W-1:0]         addr,
  input  logic [NUM_FWD-1:0]            fwd_we,
  input  logic [REG_ADDR_W*NUM_FWD-1:0] fwd_waddr,
  input  logic [DATA_W*NUM_FWD-1:0]     fwd_wdata,
  input  logic [NUM_FWD-1:0]            fwd_is_load,
  input  logic [DATA_W-1:0]             rf_rdata,
  output logic [DATA_W-1:0]             operand,
  output logic                          hit,
  output logic                          load_hit
);

  // NOTE: every output gets a default before the loop, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    operand  = rf_rdata;
    hit      = 1'b0;
    load_hit = 1'b0;
    if (addr == ZERO_REG) begin
      operand = '0;
    end else begin
      // NOTE: blocking assignments let later iterations see 'hit' already set,
      // which is what makes the lowest-numbered channel the winner.
      for (int k = 0; k < NUM_FWD; k++) begin
        if (!hit && fwd_we[k] && (fwd_waddr[k*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
          hit      = 1'b1;
          operand  = fwd_wdata[k*DATA_W +: DATA_W];
          load_hit = fwd_is_load[k];
        end
      end
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// ID operand stage: PC/valid stage register, instruction hold across stalls,
// rs/rt operand forwarding and the load-use interlock with its stall counter.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32,
  parameter int STALL_W = STALL_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic                  if_valid,
  input  logic [DATA_W-1:0]     if_pc,
  input  logic [INST_W-1:0]     inst_sram_rdata,
  input  logic                  use_rs,
  input  logic                  use_rt,
  input  logic [DATA_W-1:0]     rf_rdata1,
  input  logic [DATA_W-1:0]     rf_rdata2,
  id_operand_stage_if.slave     fwd,
  output logic                  id_valid,
  output logic [DATA_W-1:0]     id_pc,
  output logic [INST_W-1:0]     id_inst,
  output logic [REG_ADDR_W-1:0] rs_addr,
  output logic [REG_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]     opnd1,
  output logic [DATA_W-1:0]     opnd2,
  output logic                  stallreq,
  output logic [15:0]           perf_lu_stall
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              hold_full_q, hold_full_d;
  logic [INST_W-1:0] hold_inst_q, hold_inst_d;
  logic [15:0]       perf_q, perf_d;
  stage_op_e         stage_op;

  logic rs_hit, rt_hit, rs_load_hit, rt_load_hit;
  logic stall_unused;

  // Only the ID and next-stage bits of the shared stall bus matter here.
  assign stall_unused = ^{stall, rs_hit, rt_hit};

  assign stage_op = decode_stage_op(flush, stall[STALL_IDX_ID], stall[STALL_IDX_NEXT]);

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    hold_full_d = hold_full_q;
    hold_inst_d = hold_inst_q;
    unique case (stage_op)
      STG_FLUSH, STG_BUBBLE: begin
        valid_d     = 1'b0;
        pc_d        = '0;
        hold_full_d = 1'b0;
        hold_inst_d = '0;
      end
      STG_ADVANCE: begin
        valid_d     = if_valid;
        pc_d        = if_pc;
        hold_full_d = 1'b0;
        hold_inst_d = '0;
      end
      default: begin
        // The SRAM word is only valid for one cycle; latch it on the first frozen cycle.
        if (valid_q && !hold_full_q) begin
          hold_full_d = 1'b1;
          hold_inst_d = inst_sram_rdata;
        end
      end
    endcase
  end

  always_comb begin
    perf_d = perf_q;
    if (stallreq && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
  end

  // NOTE: the hold register is an ordinary flop, so it is reset along with the
  // rest; id_inst must not expose pre-reset contents after a mid-stall reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      hold_full_q <= 1'b0;
      hold_inst_q <= '0;
      perf_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      hold_full_q <= hold_full_d;
      hold_inst_q <= hold_inst_d;
      perf_q      <= perf_d;
    end
  end

  assign id_valid      = valid_q;
  assign id_pc         = pc_q;
  assign id_inst       = !valid_q ? '0 : (hold_full_q ? hold_inst_q : inst_sram_rdata);
  assign rs_addr       = id_inst[25:21];
  assign rt_addr       = id_inst[20:16];
  assign perf_lu_stall = perf_q;

  fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W)) u_fwd_rs (
    .addr        (rs_addr),
    .fwd_we      (fwd.fwd_we),
    .fwd_waddr   (fwd.fwd_waddr),
    .fwd_wdata   (fwd.fwd_wdata),
    .fwd_is_load (fwd.fwd_is_load),
    .rf_rdata    (rf_rdata1),
    .operand     (opnd1),
    .hit         (rs_hit),
    .load_hit    (rs_load_hit)
  );

  fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W)) u_fwd_rt (
    .addr        (rt_addr),
    .fwd_we      (fwd.fwd_we),
    .fwd_waddr   (fwd.fwd_waddr),
    .fwd_wdata   (fwd.fwd_wdata),
    .fwd_is_load (fwd.fwd_is_load),
    .rf_rdata    (rf_rdata2),
    .operand     (opnd2),
    .hit         (rt_hit),
    .load_hit    (rt_load_hit)
  );

  // Interlock only on an operand the instruction really reads.
  assign stallreq = valid_q && ((use_rs && rs_load_hit) || (use_rt && rt_load_hit));

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural model of the stage.
module tb_id_operand_stage;
  import id_operand_stage_pkg::*;

  localparam int NF = 3;
  localparam logic [5:0] ST_RUN    = 6'b000000;
  localparam logic [5:0] ST_BUBBLE = 6'b000010;
  localparam logic [5:0] ST_FREEZE = 6'b000110;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush, if_valid, use_rs, use_rt;
  logic [31:0] if_pc, inst_sram_rdata, rf_rdata1, rf_rdata2;
  logic        id_valid, stallreq;
  logic [31:0] id_pc, id_inst, opnd1, opnd2;
  logic [4:0]  rs_addr, rt_addr;
  logic [15:0] perf_lu_stall;

  // Forwarding channels as the bench sees them; packed onto the bus in settle().
  logic        ch_we   [NF];
  logic [4:0]  ch_addr [NF];
  logic [31:0] ch_data [NF];
  logic        ch_ld   [NF];

  // Behavioural model state.
  bit          m_valid, m_held;
  logic [31:0] m_pc, m_hold_inst;
  int          m_perf;

  int n_cmp = 0;
  int n_bad = 0;

  id_operand_stage_if #(.NUM_FWD(NF), .DATA_W(32)) fwd_bus ();

  id_operand_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .inst_sram_rdata (inst_sram_rdata),
    .use_rs          (use_rs),
    .use_rt          (use_rt),
    .rf_rdata1       (rf_rdata1),
    .rf_rdata2       (rf_rdata2),
    .fwd             (fwd_bus),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .rs_addr         (rs_addr),
    .rt_addr         (rt_addr),
    .opnd1           (opnd1),
    .opnd2           (opnd2),
    .stallreq        (stallreq),
    .perf_lu_stall   (perf_lu_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_inst();
    if (!m_valid) return 32'h0;
    return m_held ? m_hold_inst : inst_sram_rdata;
  endfunction

  // Youngest channel writing the register wins; register 0 always reads zero.
  function automatic logic [31:0] m_opnd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'h0;
    for (int k = 0; k < NF; k++)
      if (ch_we[k] && ch_addr[k] == a) return ch_data[k];
    return rf;
  endfunction

  function automatic bit m_load(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    for (int k = 0; k < NF; k++)
      if (ch_we[k] && ch_addr[k] == a) return ch_ld[k];
    return 1'b0;
  endfunction

  function automatic bit m_stallreq();
    logic [31:0] inst;
    inst = m_inst();
    return m_valid && ((use_rs && m_load(inst[25:21])) || (use_rt && m_load(inst[20:16])));
  endfunction

  task automatic settle();
    logic [31:0] inst;
    for (int k = 0; k < NF; k++) begin
      fwd_bus.fwd_we[k]          = ch_we[k];
      fwd_bus.fwd_waddr[k*5 +: 5] = ch_addr[k];
      fwd_bus.fwd_wdata[k*32 +: 32] = ch_data[k];
      fwd_bus.fwd_is_load[k]     = ch_ld[k];
    end
    #1;
    inst = m_inst();
    check("valid", id_valid, m_valid);
    check("pc", id_pc, m_pc);
    check("inst", id_inst, inst);
    check("rs_addr", rs_addr, inst[25:21]);
    check("rt_addr", rt_addr, inst[20:16]);
    check("opnd1", opnd1, m_opnd(inst[25:21], rf_rdata1));
    check("opnd2", opnd2, m_opnd(inst[20:16], rf_rdata2));
    check("stallreq", stallreq, m_stallreq());
    check("perf", perf_lu_stall, m_perf);
  endtask

  task automatic tick();
    bit sr;
    sr = m_stallreq();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_pc = 0; m_held = 0; m_hold_inst = 0; m_perf = 0;
    end else begin
      if (sr && m_perf < 16'hFFFF) m_perf++;
      if (flush || (stall[1] && !stall[2])) begin
        m_valid = 0; m_pc = 0; m_held = 0; m_hold_inst = 0;
      end else if (!stall[1]) begin
        m_valid = if_valid; m_pc = if_pc; m_held = 0; m_hold_inst = 0;
      end else if (m_valid && !m_held) begin
        m_held = 1; m_hold_inst = inst_sram_rdata;
      end
    end
    #1;
  endtask

  task automatic clear_fwd();
    for (int k = 0; k < NF; k++) begin
      ch_we[k] = 0; ch_addr[k] = 0; ch_data[k] = 0; ch_ld[k] = 0;
    end
  endtask

  // Advance one instruction into the stage, then present its word and freeze.
  task automatic load_inst(input logic [31:0] pc, input logic [31:0] inst);
    stall = ST_RUN; if_valid = 1; if_pc = pc;
    settle(); tick();
    inst_sram_rdata = inst; stall = ST_FREEZE; if_valid = 0;
  endtask

  initial begin
    logic [31:0] r;
    rst = 1; stall = ST_RUN; flush = 0; if_valid = 0; if_pc = 0;
    inst_sram_rdata = 32'h0; use_rs = 0; use_rt = 0; rf_rdata1 = 32'h55; rf_rdata2 = 32'h66;
    m_valid = 0; m_held = 0; m_pc = 0; m_hold_inst = 0; m_perf = 0;
    clear_fwd();
    tick(); tick();
    inst_sram_rdata = 32'h3C010001;
    settle();
    check("rst_valid", id_valid, 0);
    check("rst_inst", id_inst, 0);
    check("rst_opnd1", opnd1, 0);
    check("rst_perf", perf_lu_stall, 0);
    rst = 0;

    // Reset-vector fetch: LUI r1.
    load_inst(32'hBFC00000, 32'h3C010001);
    rf_rdata1 = 32'h1234;
    settle();
    check("boot_valid", id_valid, 1);
    check("boot_pc", id_pc, 32'hBFC00000);
    check("boot_rs", rs_addr, 0);
    check("boot_rt", rt_addr, 1);
    check("boot_opnd1", opnd1, 0);
    tick();

    // Forwarding priority on rs = r8.
    load_inst(32'h100, 32'h01000000);
    rf_rdata1 = 32'h33;
    ch_we[0] = 1; ch_addr[0] = 8; ch_data[0] = 32'h11;
    ch_we[1] = 1; ch_addr[1] = 8; ch_data[1] = 32'h22;
    settle(); check("prio_ch0", opnd1, 32'h11);
    ch_we[0] = 0;
    settle(); check("prio_ch1", opnd1, 32'h22);
    ch_we[1] = 0;
    settle(); check("prio_rf", opnd1, 32'h33);
    tick();

    // r0 never forwards, even from a load.
    load_inst(32'h104, 32'h00090000);
    clear_fwd();
    ch_we[0] = 1; ch_addr[0] = 0; ch_data[0] = 32'hFFFFFFFF; ch_ld[0] = 1; use_rs = 1;
    settle();
    check("r0_opnd1", opnd1, 0);
    check("r0_stall", stallreq, 0);

    // Load-use on rt = r9.
    ch_addr[0] = 9; use_rs = 0; use_rt = 1;
    settle(); check("lu_stall", stallreq, 1);
    tick();
    settle(); check("lu_perf", perf_lu_stall, 1);
    use_rt = 0;
    settle(); check("lu_unused", stallreq, 0);
    // An older non-load match on the same register must not hide the young load.
    use_rt = 1; ch_we[2] = 1; ch_addr[2] = 9; ch_ld[2] = 0;
    settle(); check("lu_young", stallreq, 1);
    clear_fwd(); use_rt = 0;
    tick();

    // Instruction hold across a 3-cycle stall.
    load_inst(32'h200, 32'h00851021);
    settle(); tick();
    inst_sram_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      settle(); check("hold_inst", id_inst, 32'h00851021);
      tick();
    end
    stall = ST_RUN; if_valid = 1; if_pc = 32'h204;
    settle(); tick();
    inst_sram_rdata = 32'h24420001; stall = ST_FREEZE;
    settle();
    check("rel_inst", id_inst, 32'h24420001);
    check("rel_pc", id_pc, 32'h204);
    tick();

    // Flush together with a hold capture: clear wins.
    load_inst(32'h300, 32'h8C430004);
    flush = 1;
    settle(); tick();
    flush = 0;
    settle();
    check("flush_valid", id_valid, 0);
    check("flush_inst", id_inst, 0);
    tick();

    // Reset in the middle of a stall discards the held word.
    load_inst(32'h400, 32'hAC450008);
    settle(); tick();
    rst = 1; settle(); tick();
    rst = 0; inst_sram_rdata = 32'h11111111;
    settle();
    check("rstmid_valid", id_valid, 0);
    check("rstmid_inst", id_inst, 0);
    load_inst(32'h500, 32'h00C73020);
    settle(); check("rstmid_new", id_inst, 32'h00C73020);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: stall = ST_RUN;
        1: stall = ST_BUBBLE;
        2: stall = ST_FREEZE;
        default: stall = 6'($urandom);
      endcase
      if_valid = $urandom_range(0, 1);
      if_pc = $urandom;
      r = $urandom;
      r[25:21] = 5'($urandom_range(0, 4));
      r[20:16] = 5'($urandom_range(0, 4));
      inst_sram_rdata = r;
      use_rs = $urandom_range(0, 1);
      use_rt = $urandom_range(0, 1);
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      for (int k = 0; k < NF; k++) begin
        ch_we[k] = $urandom_range(0, 1);
        ch_addr[k] = 5'($urandom_range(0, 4));
        ch_data[k] = $urandom;
        ch_ld[k] = ($urandom_range(0, 3) == 0);
      end
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
